// File: rtl/cr_huf_comp_is_multi.sv
// Multi-lane insertion sorter for the Huffman compressor: accumulates symbol/count
// pairs into a bounded frequency-ordered table per block, then drains it valid/ready.
module cr_huf_comp_is_multi #(
  parameter int NUM_LANES   = 4,
  parameter int DAT_WIDTH   = 9,
  parameter int CNT_WIDTH   = 16,
  parameter int SEQID_WIDTH = 4,
  parameter int DEPTH       = 32,
  parameter int ASCENDING   = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_LANES-1:0]              in_vld,
  input  logic [NUM_LANES*DAT_WIDTH-1:0]    in_sym,
  input  logic [NUM_LANES*CNT_WIDTH-1:0]    in_cnt,
  input  logic [SEQID_WIDTH-1:0]            in_seq_id,
  input  logic                              in_eob,
  output logic                              in_rdy,
  output logic                              out_vld,
  input  logic                              out_rdy,
  output logic [DAT_WIDTH-1:0]              out_sym,
  output logic [CNT_WIDTH-1:0]              out_freq,
  output logic                              out_last,
  output logic                              out_empty,
  output logic [$clog2(DEPTH+1)-1:0]        out_sym_unique,
  output logic [DAT_WIDTH-1:0]              out_sym_lo,
  output logic [DAT_WIDTH-1:0]              out_sym_hi,
  output logic [SEQID_WIDTH-1:0]            out_seq_id,
  output logic                              out_ovfl
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {ACCUM, INSERT, DRAIN} state_t;

  state_t                           state_q, state_d;
  logic                             in_rdy_q, in_rdy_d;
  logic [NUM_LANES-1:0]             hold_vld_q, hold_vld_d;
  logic [NUM_LANES*DAT_WIDTH-1:0]   hold_sym_q, hold_sym_d;
  logic [NUM_LANES*CNT_WIDTH-1:0]   hold_cnt_q, hold_cnt_d;
  logic                             hold_eob_q, hold_eob_d;
  logic [SEQID_WIDTH-1:0]           seq_q, seq_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [CW-1:0]                    pres_q, pres_d;
  logic                             ovfl_q, ovfl_d;
  logic                             any_q, any_d;
  logic [DAT_WIDTH-1:0]             lo_q, lo_d, hi_q, hi_d;

  logic                             out_vld_q, out_vld_d;
  logic [DAT_WIDTH-1:0]             out_sym_q, out_sym_d;
  logic [CNT_WIDTH-1:0]             out_freq_q, out_freq_d;
  logic                             out_last_q, out_last_d;
  logic                             out_empty_q, out_empty_d;
  logic [CW-1:0]                    out_uniq_q, out_uniq_d;
  logic [DAT_WIDTH-1:0]             out_lo_q, out_lo_d, out_hi_q, out_hi_d;
  logic [SEQID_WIDTH-1:0]           out_seq_q, out_seq_d;
  logic                             out_ovfl_q, out_ovfl_d;

  logic [DAT_WIDTH-1:0]             tab_sym_q  [DEPTH];
  logic [DAT_WIDTH-1:0]             tab_sym_d  [DEPTH];
  logic [CNT_WIDTH-1:0]             tab_freq_q [DEPTH];
  logic [CNT_WIDTH-1:0]             tab_freq_d [DEPTH];

  logic [NUM_LANES-1:0]             lane_oh;
  logic [DAT_WIDTH-1:0]             new_sym;
  logic [CNT_WIDTH-1:0]             new_cnt;
  logic [CW-1:0]                    pos;
  logic                             full;
  logic                             place;
  logic [CW-1:0]                    idx;

  // Lowest-index valid lane and its insertion slot (entries with freq >= new stay ahead).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    lane_oh = '0;
    new_sym = '0;
    new_cnt = '0;
    for (int l = NUM_LANES - 1; l >= 0; l--) begin
      if (hold_vld_q[l]) begin
        lane_oh    = '0;
        lane_oh[l] = 1'b1;
        new_sym    = hold_sym_q[l*DAT_WIDTH +: DAT_WIDTH];
        new_cnt    = hold_cnt_q[l*CNT_WIDTH +: CNT_WIDTH];
      end
    end
    pos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < cnt_q) && (tab_freq_q[i] >= new_cnt)) pos = pos + CW'(1);
    end
    full  = (cnt_q == CW'(DEPTH));
    place = (pos != CW'(DEPTH));
    if (ASCENDING != 0) idx = cnt_q - CW'(1) - pres_q;
    else                idx = pres_q;
  end

  always_comb begin
    state_d     = state_q;
    in_rdy_d    = in_rdy_q;
    hold_vld_d  = hold_vld_q;
    hold_sym_d  = hold_sym_q;
    hold_cnt_d  = hold_cnt_q;
    hold_eob_d  = hold_eob_q;
    seq_d       = seq_q;
    cnt_d       = cnt_q;
    pres_d      = pres_q;
    ovfl_d      = ovfl_q;
    any_d       = any_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    out_vld_d   = out_vld_q;
    out_sym_d   = out_sym_q;
    out_freq_d  = out_freq_q;
    out_last_d  = out_last_q;
    out_empty_d = out_empty_q;
    out_uniq_d  = out_uniq_q;
    out_lo_d    = out_lo_q;
    out_hi_d    = out_hi_q;
    out_seq_d   = out_seq_q;
    out_ovfl_d  = out_ovfl_q;
    tab_sym_d   = tab_sym_q;
    tab_freq_d  = tab_freq_q;

    unique case (state_q)
      ACCUM: begin
        in_rdy_d = 1'b1;
        if (in_rdy_q && ((|in_vld) || in_eob)) begin
          hold_vld_d = in_vld;
          hold_sym_d = in_sym;
          hold_cnt_d = in_cnt;
          hold_eob_d = in_eob;
          seq_d      = in_seq_id;
          in_rdy_d   = 1'b0;
          state_d    = INSERT;
        end
      end

      INSERT: begin
        hold_vld_d = hold_vld_q & ~lane_oh;
        if ((|hold_vld_q) && (new_cnt != '0)) begin
          any_d = 1'b1;
          lo_d  = (!any_q || (new_sym < lo_q)) ? new_sym : lo_q;
          hi_d  = (!any_q || (new_sym > hi_q)) ? new_sym : hi_q;
          if (full)  ovfl_d = 1'b1;
          else       cnt_d  = cnt_q + CW'(1);
          if (place) begin
            for (int i = 1; i < DEPTH; i++) begin
              if (CW'(i) > pos) begin
                tab_sym_d[i]  = tab_sym_q[i-1];
                tab_freq_d[i] = tab_freq_q[i-1];
              end
            end
            for (int i = 0; i < DEPTH; i++) begin
              if (CW'(i) == pos) begin
                tab_sym_d[i]  = new_sym;
                tab_freq_d[i] = new_cnt;
              end
            end
          end
        end
        if ((hold_vld_q & ~lane_oh) == '0) begin
          if (hold_eob_q) begin
            state_d = DRAIN;
          end else begin
            state_d  = ACCUM;
            in_rdy_d = 1'b1;
          end
        end
      end

      DRAIN: begin
        if (out_vld_q && out_rdy && out_last_q) begin
          state_d     = ACCUM;
          in_rdy_d    = 1'b1;
          cnt_d       = '0;
          pres_d      = '0;
          ovfl_d      = 1'b0;
          any_d       = 1'b0;
          lo_d        = '0;
          hi_d        = '0;
          out_vld_d   = 1'b0;
          out_sym_d   = '0;
          out_freq_d  = '0;
          out_last_d  = 1'b0;
          out_empty_d = 1'b0;
          out_uniq_d  = '0;
          out_lo_d    = '0;
          out_hi_d    = '0;
          out_seq_d   = '0;
          out_ovfl_d  = 1'b0;
        end else if (!out_vld_q || out_rdy) begin
          // First cycle of DRAIN primes entry 0; afterwards each handshake loads the next.
          out_vld_d   = 1'b1;
          out_uniq_d  = cnt_q;
          out_lo_d    = lo_q;
          out_hi_d    = hi_q;
          out_seq_d   = seq_q;
          out_ovfl_d  = ovfl_q;
          out_empty_d = (cnt_q == '0);
          pres_d      = pres_q + CW'(1);
          if (cnt_q == '0) begin
            out_sym_d  = '0;
            out_freq_d = '0;
            out_last_d = 1'b1;
          end else begin
            out_sym_d  = tab_sym_q[idx[IW-1:0]];
            out_freq_d = tab_freq_q[idx[IW-1:0]];
            out_last_d = (pres_q == cnt_q - CW'(1));
          end
        end
      end

      default: state_d = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      in_rdy_q    <= 1'b0;
      hold_vld_q  <= '0;
      hold_sym_q  <= '0;
      hold_cnt_q  <= '0;
      hold_eob_q  <= 1'b0;
      seq_q       <= '0;
      cnt_q       <= '0;
      pres_q      <= '0;
      ovfl_q      <= 1'b0;
      any_q       <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      out_vld_q   <= 1'b0;
      out_sym_q   <= '0;
      out_freq_q  <= '0;
      out_last_q  <= 1'b0;
      out_empty_q <= 1'b0;
      out_uniq_q  <= '0;
      out_lo_q    <= '0;
      out_hi_q    <= '0;
      out_seq_q   <= '0;
      out_ovfl_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_rdy_q    <= in_rdy_d;
      hold_vld_q  <= hold_vld_d;
      hold_sym_q  <= hold_sym_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_eob_q  <= hold_eob_d;
      seq_q       <= seq_d;
      cnt_q       <= cnt_d;
      pres_q      <= pres_d;
      ovfl_q      <= ovfl_d;
      any_q       <= any_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      out_vld_q   <= out_vld_d;
      out_sym_q   <= out_sym_d;
      out_freq_q  <= out_freq_d;
      out_last_q  <= out_last_d;
      out_empty_q <= out_empty_d;
      out_uniq_q  <= out_uniq_d;
      out_lo_q    <= out_lo_d;
      out_hi_q    <= out_hi_d;
      out_seq_q   <= out_seq_d;
      out_ovfl_q  <= out_ovfl_d;
    end
  end

  // NOTE: table storage has no reset; cnt_q alone defines which entries are live.
  always_ff @(posedge clk) begin
    tab_sym_q  <= tab_sym_d;
    tab_freq_q <= tab_freq_d;
  end

  assign in_rdy         = in_rdy_q;
  assign out_vld        = out_vld_q;
  assign out_sym        = out_sym_q;
  assign out_freq       = out_freq_q;
  assign out_last       = out_last_q;
  assign out_empty      = out_empty_q;
  assign out_sym_unique = out_uniq_q;
  assign out_sym_lo     = out_lo_q;
  assign out_sym_hi     = out_hi_q;
  assign out_seq_id     = out_seq_q;
  assign out_ovfl       = out_ovfl_q;

endmodule

// File: tb/tb_cr_huf_comp_is_multi.sv
// Scoreboard bench: three sorter instances (default, ASCENDING=1, DEPTH=4) driven one at a time.
module tb_cr_huf_comp_is_multi;

  typedef struct packed {
    logic [1:0]  d;
    logic [63:0] v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_rdy;
  bit          toggle;

  logic [3:0]  i_vld [3];
  logic [35:0] i_sym [3];
  logic [63:0] i_cnt [3];
  logic [3:0]  i_seq [3];
  logic        i_eob [3];
  logic        i_rdy [3];
  logic        o_vld [3];
  logic [8:0]  o_sym [3];
  logic [15:0] o_freq [3];
  logic        o_last [3];
  logic        o_empty [3];
  logic [5:0]  o_uniq [2];
  logic [2:0]  uniq_d4;
  logic [8:0]  o_lo [3];
  logic [8:0]  o_hi [3];
  logic [3:0]  o_seq [3];
  logic        o_ovfl [3];

  exp_t        exp_q [$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [63:0] snap [3];
  bit          snap_v [3];

  always #5 clk = ~clk;

  cr_huf_comp_is_multi u_desc (
    .clk(clk), .rst(rst), .in_vld(i_vld[0]), .in_sym(i_sym[0]), .in_cnt(i_cnt[0]),
    .in_seq_id(i_seq[0]), .in_eob(i_eob[0]), .in_rdy(i_rdy[0]), .out_vld(o_vld[0]),
    .out_rdy(out_rdy), .out_sym(o_sym[0]), .out_freq(o_freq[0]), .out_last(o_last[0]),
    .out_empty(o_empty[0]), .out_sym_unique(o_uniq[0]), .out_sym_lo(o_lo[0]),
    .out_sym_hi(o_hi[0]), .out_seq_id(o_seq[0]), .out_ovfl(o_ovfl[0]));

  cr_huf_comp_is_multi #(.ASCENDING(1)) u_asc (
    .clk(clk), .rst(rst), .in_vld(i_vld[1]), .in_sym(i_sym[1]), .in_cnt(i_cnt[1]),
    .in_seq_id(i_seq[1]), .in_eob(i_eob[1]), .in_rdy(i_rdy[1]), .out_vld(o_vld[1]),
    .out_rdy(out_rdy), .out_sym(o_sym[1]), .out_freq(o_freq[1]), .out_last(o_last[1]),
    .out_empty(o_empty[1]), .out_sym_unique(o_uniq[1]), .out_sym_lo(o_lo[1]),
    .out_sym_hi(o_hi[1]), .out_seq_id(o_seq[1]), .out_ovfl(o_ovfl[1]));

  cr_huf_comp_is_multi #(.DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .in_vld(i_vld[2]), .in_sym(i_sym[2]), .in_cnt(i_cnt[2]),
    .in_seq_id(i_seq[2]), .in_eob(i_eob[2]), .in_rdy(i_rdy[2]), .out_vld(o_vld[2]),
    .out_rdy(out_rdy), .out_sym(o_sym[2]), .out_freq(o_freq[2]), .out_last(o_last[2]),
    .out_empty(o_empty[2]), .out_sym_unique(uniq_d4), .out_sym_lo(o_lo[2]),
    .out_sym_hi(o_hi[2]), .out_seq_id(o_seq[2]), .out_ovfl(o_ovfl[2]));

  function automatic logic [63:0] pk(input logic [8:0] sym, input logic [15:0] fr,
                                     input logic last, input logic empty, input logic [5:0] uq,
                                     input logic [8:0] lo, input logic [8:0] hi,
                                     input logic [3:0] seq, input logic ovfl);
    return {8'd0, sym, fr, last, empty, uq, lo, hi, seq, ovfl};
  endfunction

  function automatic logic [63:0] cur_out(input int d);
    logic [5:0] uq;
    uq = (d == 2) ? {3'b000, uniq_d4} : o_uniq[d];
    return pk(o_sym[d], o_freq[d], o_last[d], o_empty[d], uq, o_lo[d], o_hi[d], o_seq[d], o_ovfl[d]);
  endfunction

  task automatic check(input string name, input bit ok, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
  endtask

  task automatic push(input int d, input int sym, input int fr, input bit last, input bit empty,
                      input int uq, input int lo, input int hi, input int seq, input bit ovfl);
    exp_t e;
    e.d = 2'(d);
    e.v = pk(9'(sym), 16'(fr), last, empty, 6'(uq), 9'(lo), 9'(hi), 4'(seq), ovfl);
    exp_q.push_back(e);
  endtask

  // Caller is aligned at posedge+1; returns aligned at posedge+1 after acceptance.
  task automatic send(input int d, input logic [3:0] vld, input logic [35:0] syms,
                      input logic [63:0] cnts, input logic [3:0] seq, input logic eob);
    int n = 0;
    while (!i_rdy[d] && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) check("in_rdy_timeout", 1'b0, 64'(i_rdy[d]), 64'd1);
    i_vld[d] = vld; i_sym[d] = syms; i_cnt[d] = cnts; i_seq[d] = seq; i_eob[d] = eob;
    @(posedge clk); #1;
    i_vld[d] = '0; i_sym[d] = '0; i_cnt[d] = '0; i_seq[d] = '0; i_eob[d] = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_rdy = toggle ? ~out_rdy : 1'b1;
    end
  end

  // Monitor: pops an expectation on every output handshake and checks holds while stalled.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        logic [63:0] cur;
        exp_t        e;
        cur = cur_out(d);
        if (snap_v[d]) check("hold_while_stalled", o_vld[d] && (cur == snap[d]), cur, snap[d]);
        snap_v[d] = o_vld[d] && !out_rdy;
        snap[d]   = cur;
        if (o_vld[d]) check("in_rdy_low_in_drain", !i_rdy[d], 64'(i_rdy[d]), 64'd0);
        if (o_vld[d] && out_rdy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_entry", 1'b0, cur, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("entry", (int'(e.d) == d) && (e.v == cur), cur, e.v);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    toggle = 1'b0;
    for (int d = 0; d < 3; d++) begin
      i_vld[d] = '0; i_sym[d] = '0; i_cnt[d] = '0; i_seq[d] = '0; i_eob[d] = 1'b0;
      snap_v[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++)
      check("reset_state", (cur_out(d) == 64'd0) && !o_vld[d] && !i_rdy[d], cur_out(d), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_rdy_before_edge", !i_rdy[0], 64'(i_rdy[0]), 64'd0);
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) check("in_rdy_after_reset", i_rdy[d], 64'(i_rdy[d]), 64'd1);

    // Four-lane beat, descending order with a stable tie.
    push(0, 7, 20, 0, 0, 4, 1, 9, 5, 0);
    push(0, 3,  5, 0, 0, 4, 1, 9, 5, 0);
    push(0, 1,  5, 0, 0, 4, 1, 9, 5, 0);
    push(0, 9,  1, 1, 0, 4, 1, 9, 5, 0);
    send(0, 4'b1111, {9'd9, 9'd1, 9'd7, 9'd3}, {16'd1, 16'd5, 16'd20, 16'd5}, 4'd5, 1'b1);
    wait_empty("drain_desc");

    // Same beat into the ascending instance.
    push(1, 9,  1, 0, 0, 4, 1, 9, 5, 0);
    push(1, 1,  5, 0, 0, 4, 1, 9, 5, 0);
    push(1, 3,  5, 0, 0, 4, 1, 9, 5, 0);
    push(1, 7, 20, 1, 0, 4, 1, 9, 5, 0);
    send(1, 4'b1111, {9'd9, 9'd1, 9'd7, 9'd3}, {16'd1, 16'd5, 16'd20, 16'd5}, 4'd5, 1'b1);
    wait_empty("drain_asc");

    // Eob-only beat: table must have been cleared by the previous drain.
    push(0, 0, 0, 1, 1, 0, 0, 0, 4'hA, 0);
    send(0, 4'b0000, 36'd0, 64'd0, 4'hA, 1'b1);
    wait_empty("drain_empty");

    // DEPTH=4 overflow: tail replacement, drop-on-full, zero-count lane excluded from lo.
    push(2, 11, 10, 0, 0, 4, 11, 20, 3, 1);
    push(2, 15,  9, 0, 0, 4, 11, 20, 3, 1);
    push(2, 13,  8, 0, 0, 4, 11, 20, 3, 1);
    push(2, 16,  3, 1, 0, 4, 11, 20, 3, 1);
    send(2, 4'b1111, {9'd14, 9'd13, 9'd12, 9'd11}, {16'd1, 16'd8, 16'd2, 16'd10}, 4'd2, 1'b0);
    send(2, 4'b1111, {9'd20, 9'd1, 9'd16, 9'd15}, {16'd1, 16'd0, 16'd3, 16'd9}, 4'd3, 1'b1);
    wait_empty("drain_ovfl");

    // Back-pressure: out_rdy toggles every cycle; invalid lane 3 must be ignored.
    toggle = 1'b1;
    push(0, 6, 9, 0, 0, 3, 4, 6, 7, 0);
    push(0, 4, 2, 0, 0, 3, 4, 6, 7, 0);
    push(0, 5, 2, 1, 0, 3, 4, 6, 7, 0);
    send(0, 4'b0111, {9'd30, 9'd6, 9'd5, 9'd4}, {16'd50, 16'd9, 16'd2, 16'd2}, 4'd7, 1'b1);
    wait_empty("drain_toggle");
    repeat (3) @(posedge clk);
    #1;
    toggle = 1'b0;

    // Reset after two entries of a five-entry drain.
    push(0, 8, 5, 0, 0, 5, 1, 8, 8, 0);
    push(0, 4, 4, 0, 0, 5, 1, 8, 8, 0);
    push(0, 3, 3, 0, 0, 5, 1, 8, 8, 0);
    push(0, 2, 2, 0, 0, 5, 1, 8, 8, 0);
    push(0, 1, 1, 1, 0, 5, 1, 8, 8, 0);
    send(0, 4'b1111, {9'd4, 9'd3, 9'd2, 9'd1}, {16'd4, 16'd3, 16'd2, 16'd1}, 4'd8, 1'b0);
    send(0, 4'b0100, {9'd0, 9'd8, 9'd0, 9'd0}, {16'd0, 16'd5, 16'd0, 16'd0}, 4'd8, 1'b1);
    begin
      int n = 0;
      while (exp_q.size() > 3 && n < 500) begin
        @(posedge clk); #1;
        n++;
      end
      check("two_entries_seen", exp_q.size() == 3, 64'(exp_q.size()), 64'd3);
    end
    rst = 1'b1;
    #1;
    check("reset_mid_drain", (cur_out(0) == 64'd0) && !o_vld[0] && !i_rdy[0], cur_out(0), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_rdy_after_mid_reset", i_rdy[0], 64'(i_rdy[0]), 64'd1);
    push(0, 4, 7, 0, 0, 2, 2, 4, 9, 0);
    push(0, 2, 6, 1, 0, 2, 2, 4, 9, 0);
    send(0, 4'b0011, {9'd0, 9'd0, 9'd4, 9'd2}, {16'd0, 16'd0, 16'd7, 16'd6}, 4'd9, 1'b1);
    wait_empty("drain_after_reset");

    repeat (10) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
